// File: rtl/sos_sched_pkg.sv
// Shared types and constants for the SOS channel scheduler.
package sos_sched_pkg;

    // Scheduler FSM encoding.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StWback = 2'd3
    } sched_state_e;

    // Default engine watchdog limit, in WAIT cycles.
    localparam int unsigned DEFAULT_TIMEOUT = 64;

    // Channel index width; never collapses to zero bits.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first pending channel at or after rr_ptr, searching upward with wrap.
// Purely combinational.
module rr_arbiter
    import sos_sched_pkg::*;
#(
    parameter int unsigned  NUM_CH = 4,
    localparam int unsigned CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CH_W-1:0]   rr_ptr,
    output logic [NUM_CH-1:0] grant_oh,
    output logic [CH_W-1:0]   grant_idx,
    output logic              grant_valid
);

    logic [CH_W-1:0] idx;

    // Walk the channels starting at rr_ptr; the first hit wins.
    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = CH_W'((32'(rr_ptr) + k) % NUM_CH);
            if (!grant_valid && pending[idx]) begin
                grant_valid   = 1'b1;
                grant_idx     = idx;
                grant_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sos_channel_scheduler.sv
// Time-multiplexes one stateless SOS engine across NUM_CH sample channels.
// Holds per-channel samples and the w1/w2 delay state, issues one channel at a time to the
// engine, and writes the updated state back when the engine reports done.
module sos_channel_scheduler
    import sos_sched_pkg::*;
#(
    parameter int unsigned  NUM_CH     = 4,
    parameter int unsigned  DATA_SIZE  = 24,
    parameter int unsigned  STATE_SIZE = 32,
    parameter int unsigned  TIMEOUT    = DEFAULT_TIMEOUT,
    localparam int unsigned CH_W       = ch_width(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [NUM_CH-1:0]           ch_valid,
    input  logic [NUM_CH*DATA_SIZE-1:0] ch_data,
    output logic                        eng_start,
    output logic [DATA_SIZE-1:0]        eng_data_in,
    output logic [STATE_SIZE-1:0]       eng_w1_in,
    output logic [STATE_SIZE-1:0]       eng_w2_in,
    input  logic                        eng_done,
    input  logic [DATA_SIZE-1:0]        eng_data_out,
    input  logic [STATE_SIZE-1:0]       eng_w1_out,
    input  logic [STATE_SIZE-1:0]       eng_w2_out,
    output logic                        out_valid,
    output logic [DATA_SIZE-1:0]        out_data,
    output logic [CH_W-1:0]             out_ch,
    output logic [NUM_CH-1:0]           overrun,
    output logic                        timeout_err
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    sched_state_e state_q, state_d;

    logic [NUM_CH-1:0]     pending_q;
    logic [NUM_CH-1:0]     overrun_q;
    logic [DATA_SIZE-1:0]  sample_q [NUM_CH];
    logic [STATE_SIZE-1:0] w1_q     [NUM_CH];
    logic [STATE_SIZE-1:0] w2_q     [NUM_CH];

    logic [NUM_CH-1:0] grant_oh;
    logic [NUM_CH-1:0] take;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_valid;

    logic [CH_W-1:0]       rr_ptr_q;
    logic [CH_W-1:0]       cur_ch_q;
    logic [DATA_SIZE-1:0]  op_data_q;
    logic [STATE_SIZE-1:0] op_w1_q;
    logic [STATE_SIZE-1:0] op_w2_q;
    logic [WD_W-1:0]       wd_q;
    logic [DATA_SIZE-1:0]  res_data_q;
    logic [STATE_SIZE-1:0] res_w1_q;
    logic [STATE_SIZE-1:0] res_w2_q;
    logic                  suppress_q;
    logic                  timeout_q;

    logic                  out_valid_q;
    logic [DATA_SIZE-1:0]  out_data_q;
    logic [CH_W-1:0]       out_ch_q;

    logic do_grant;
    logic wd_expire;
    logic wb_en;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .pending     (pending_q),
        .rr_ptr      (rr_ptr_q),
        .grant_oh    (grant_oh),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign take = do_grant ? grant_oh : '0;

    // Next-state decode and per-state strobes.
    always_comb begin
        state_d   = state_q;
        do_grant  = 1'b0;
        wd_expire = 1'b0;
        wb_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    do_grant = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (eng_done) begin
                    state_d = StWback;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    wd_expire = 1'b1;
                    state_d   = StIdle;
                end
            end
            StWback: begin
                // A flush in this same cycle beats the writeback.
                wb_en   = !flush && !suppress_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample capture, pending flags and sticky overrun per channel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q <= '0;
            overrun_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                sample_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // A strobe landing on the grant cycle refills the slot; the grant took the old data.
                if (ch_valid[i] && (!pending_q[i] || take[i])) begin
                    sample_q[i]  <= ch_data[i*DATA_SIZE +: DATA_SIZE];
                    pending_q[i] <= 1'b1;
                end else if (take[i]) begin
                    pending_q[i] <= 1'b0;
                end
                if (ch_valid[i] && pending_q[i] && !take[i]) begin
                    overrun_q[i] <= 1'b1;
                end
            end
        end
    end

    // Engine operands, watchdog, result capture and error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q   <= '0;
            cur_ch_q   <= '0;
            op_data_q  <= '0;
            op_w1_q    <= '0;
            op_w2_q    <= '0;
            wd_q       <= '0;
            res_data_q <= '0;
            res_w1_q   <= '0;
            res_w2_q   <= '0;
            suppress_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (do_grant) begin
                cur_ch_q   <= grant_idx;
                rr_ptr_q   <= (grant_idx == LAST_CH) ? '0 : grant_idx + CH_W'(1);
                op_data_q  <= sample_q[grant_idx];
                // The state store is zeroed at this same edge, so hand the engine zeros too.
                op_w1_q    <= flush ? '0 : w1_q[grant_idx];
                op_w2_q    <= flush ? '0 : w2_q[grant_idx];
                suppress_q <= 1'b0;
            end
            if (state_q == StIssue) begin
                wd_q <= '0;
            end else if (state_q == StWait) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (state_q == StWait && eng_done) begin
                res_data_q <= eng_data_out;
                res_w1_q   <= eng_w1_out;
                res_w2_q   <= eng_w2_out;
            end
            // Once operands are latched, a flush must keep the stale result out of the store.
            if (flush && (state_q == StIssue || state_q == StWait || state_q == StWback)) begin
                suppress_q <= 1'b1;
            end
            if (wd_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Per-channel w1/w2 delay-state store.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            for (int i = 0; i < NUM_CH; i++) begin
                w1_q[i] <= '0;
                w2_q[i] <= '0;
            end
        end else if (wb_en) begin
            w1_q[cur_ch_q] <= res_w1_q;
            w2_q[cur_ch_q] <= res_w2_q;
        end
    end

    // Registered result strobe, issued on the edge that leaves WBACK.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= (state_q == StWback);
            if (state_q == StWback) begin
                out_data_q <= res_data_q;
                out_ch_q   <= cur_ch_q;
            end
        end
    end

    assign eng_start   = (state_q == StIssue);
    assign eng_data_in = op_data_q;
    assign eng_w1_in   = op_w1_q;
    assign eng_w2_in   = op_w2_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_ch      = out_ch_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_sos_channel_scheduler.sv
// Directed bench for sos_channel_scheduler with a behavioural SOS engine stub.
// Stub: data_out = data_in + 1, w1_out = w1_in + 5, w2_out = w2_in + 7.
module tb_sos_channel_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [3:0]  ch_valid;
    logic [95:0] ch_data;
    logic        eng_start;
    logic [23:0] eng_data_in;
    logic [31:0] eng_w1_in;
    logic [31:0] eng_w2_in;
    logic        eng_done;
    logic [23:0] eng_data_out;
    logic [31:0] eng_w1_out;
    logic [31:0] eng_w2_out;
    logic        out_valid;
    logic [23:0] out_data;
    logic [1:0]  out_ch;
    logic [3:0]  overrun;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Engine stub controls and state.
    int          stub_delay;
    logic        stub_hang;
    logic        stray_done;
    logic        stub_busy;
    int          stub_cnt;
    logic [23:0] stub_data;
    logic [31:0] stub_w1;
    logic [31:0] stub_w2;

    always #5 clk = ~clk;

    sos_channel_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .ch_valid     (ch_valid),
        .ch_data      (ch_data),
        .eng_start    (eng_start),
        .eng_data_in  (eng_data_in),
        .eng_w1_in    (eng_w1_in),
        .eng_w2_in    (eng_w2_in),
        .eng_done     (eng_done),
        .eng_data_out (eng_data_out),
        .eng_w1_out   (eng_w1_out),
        .eng_w2_out   (eng_w2_out),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ch       (out_ch),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    // Engine stub: done pulses stub_delay cycles after the start edge unless hung.
    always @(posedge clk) begin
        if (!reset) begin
            stub_busy <= 1'b0;
            stub_cnt  <= 0;
        end else if (eng_start) begin
            stub_busy <= 1'b1;
            stub_cnt  <= stub_delay - 1;
            stub_data <= eng_data_in + 24'd1;
            stub_w1   <= eng_w1_in + 32'd5;
            stub_w2   <= eng_w2_in + 32'd7;
        end else if (stub_busy) begin
            if (stub_cnt == 0) stub_busy <= 1'b0;
            else stub_cnt <= stub_cnt - 1;
        end
    end

    assign eng_done     = (stub_busy && stub_cnt == 0 && !stub_hang) || stray_done;
    assign eng_data_out = stub_data;
    assign eng_w1_out   = stub_w1;
    assign eng_w2_out   = stub_w2;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and drop all one-cycle pulses.
    task automatic tick();
        @(negedge clk);
        ch_valid   = '0;
        flush      = 1'b0;
        stray_done = 1'b0;
    endtask

    task automatic send(input int ch, input logic [23:0] d);
        ch_valid[ch]        = 1'b1;
        ch_data[ch*24 +: 24] = d;
    endtask

    task automatic wait_start(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            tick();
            if (eng_start) seen = 1'b1;
        end
        check_eq(tag, 64'(seen), 64'd1);
    endtask

    task automatic expect_out(input string tag, input logic [1:0] ch, input logic [23:0] d,
                              output int lat);
        bit seen = 1'b0;
        lat = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            tick();
            lat++;
            if (out_valid) seen = 1'b1;
        end
        check_eq({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check_eq({tag, "_ch"}, 64'(out_ch), 64'(ch));
            check_eq({tag, "_data"}, 64'(out_data), 64'(d));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int ov;
        int st;

        reset      = 1'b0;
        flush      = 1'b0;
        ch_valid   = '0;
        ch_data    = '0;
        stray_done = 1'b0;
        stub_hang  = 1'b0;
        stub_delay = 1;

        // Reset state.
        repeat (3) tick();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_eng_start", 64'(eng_start), 64'd0);
        check_eq("rst_overrun", 64'(overrun), 64'd0);
        check_eq("rst_timeout", 64'(timeout_err), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'd0);
        check_eq("rst_eng_w1", 64'(eng_w1_in), 64'd0);
        reset = 1'b1;
        tick();

        // 1: single channel, latency and state carry-over.
        send(2, 24'h000100);
        expect_out("t1_o", 2'd2, 24'h000101, lat);
        check_eq("t1_latency", 64'(lat), 64'd5);
        tick();
        check_eq("t1_single_pulse", 64'(out_valid), 64'd0);
        send(2, 24'h000200);
        wait_start("t1_start2");
        check_eq("t1_w1_in", 64'(eng_w1_in), 64'd5);
        check_eq("t1_w2_in", 64'(eng_w2_in), 64'd7);
        check_eq("t1_data_in", 64'(eng_data_in), 64'h200);
        expect_out("t1_o2", 2'd2, 24'h000201, lat);

        // 2: fairness from rr_ptr=0, then from rr_ptr=1.
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send(i, 24'(32'h10 * (i + 1)));
        expect_out("t2_a0", 2'd0, 24'h000011, lat);
        expect_out("t2_a1", 2'd1, 24'h000021, lat);
        expect_out("t2_a2", 2'd2, 24'h000031, lat);
        expect_out("t2_a3", 2'd3, 24'h000041, lat);
        send(0, 24'h000050);
        expect_out("t2_b0", 2'd0, 24'h000051, lat);
        send(0, 24'h000060);
        send(3, 24'h000070);
        expect_out("t2_c3", 2'd3, 24'h000071, lat);
        expect_out("t2_c0", 2'd0, 24'h000061, lat);

        // 3: overrun on ch1 with a slow engine; B lands on the grant cycle, C is dropped.
        stub_delay = 10;
        send(1, 24'h0000A0);
        tick();
        send(1, 24'h0000B0);
        tick();
        send(1, 24'h0000C0);
        tick();
        check_eq("t3_overrun", 64'(overrun), 64'h2);
        expect_out("t3_oa", 2'd1, 24'h0000A1, lat);
        wait_start("t3_start_b");
        check_eq("t3_b_data_in", 64'(eng_data_in), 64'hB0);
        check_eq("t3_b_w1_in", 64'(eng_w1_in), 64'd10);
        expect_out("t3_ob", 2'd1, 24'h0000B1, lat);
        ov = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            ov += int'(out_valid);
        end
        check_eq("t3_no_third", 64'(ov), 64'd0);

        // 4: timeout on ch0, then ch3 is served and ch0 state is untouched.
        stub_delay = 1;
        stub_hang  = 1'b1;
        send(0, 24'h000AAA);
        wait_start("t4_start");
        check_eq("t4_data_in", 64'(eng_data_in), 64'hAAA);
        check_eq("t4_w1_in", 64'(eng_w1_in), 64'd15);
        check_eq("t4_w2_in", 64'(eng_w2_in), 64'd21);
        send(3, 24'h000BBB);
        ov = 0;
        for (int n = 0; n < 64; n++) begin
            tick();
            ov += int'(out_valid);
        end
        check_eq("t4_timeout_early", 64'(timeout_err), 64'd0);
        tick();
        ov += int'(out_valid);
        check_eq("t4_timeout_set", 64'(timeout_err), 64'd1);
        check_eq("t4_no_out", 64'(ov), 64'd0);
        stub_hang = 1'b0;
        wait_start("t4_next_start");
        check_eq("t4_next_data", 64'(eng_data_in), 64'hBBB);
        check_eq("t4_next_w1", 64'(eng_w1_in), 64'd10);
        check_eq("t4_next_w2", 64'(eng_w2_in), 64'd14);
        expect_out("t4_o3", 2'd3, 24'h000BBC, lat);
        send(0, 24'h000CCC);
        wait_start("t4_ch0_again");
        check_eq("t4_ch0_w1_kept", 64'(eng_w1_in), 64'd15);
        check_eq("t4_ch0_w2_kept", 64'(eng_w2_in), 64'd21);
        expect_out("t4_o0", 2'd0, 24'h000CCD, lat);

        // 5: flush while ch0 is in WAIT.
        stub_delay = 3;
        send(0, 24'h000123);
        wait_start("t5_start");
        check_eq("t5_w1_before", 64'(eng_w1_in), 64'd20);
        tick();
        flush = 1'b1;
        expect_out("t5_o", 2'd0, 24'h000124, lat);
        send(0, 24'h000456);
        wait_start("t5_start2");
        check_eq("t5_w1_zero", 64'(eng_w1_in), 64'd0);
        check_eq("t5_w2_zero", 64'(eng_w2_in), 64'd0);
        expect_out("t5_o2", 2'd0, 24'h000457, lat);

        // 6: reset mid-WAIT, then a stray done.
        check_eq("t6_overrun_sticky", 64'(overrun), 64'h2);
        check_eq("t6_timeout_sticky", 64'(timeout_err), 64'd1);
        stub_hang = 1'b1;
        send(1, 24'h000777);
        wait_start("t6_start");
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        stray_done = 1'b1;
        ov = 0;
        st = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            ov += int'(out_valid);
            st += int'(eng_start);
        end
        check_eq("t6_no_out", 64'(ov), 64'd0);
        check_eq("t6_no_start", 64'(st), 64'd0);
        check_eq("t6_out_data", 64'(out_data), 64'd0);
        check_eq("t6_out_ch", 64'(out_ch), 64'd0);
        check_eq("t6_overrun", 64'(overrun), 64'd0);
        check_eq("t6_timeout", 64'(timeout_err), 64'd0);
        check_eq("t6_eng_data_in", 64'(eng_data_in), 64'd0);
        check_eq("t6_eng_w1_in", 64'(eng_w1_in), 64'd0);
        check_eq("t6_eng_w2_in", 64'(eng_w2_in), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sos_channel_scheduler.md
Name: sos_channel_scheduler

Overview:
Time-multiplexes one shared second-order-section (SOS) filter engine across NUM_CH independent sample channels. The block does the following:
- Captures per-channel samples.
- Picks the next channel round-robin.
- Loads that channel's two delay-state words into the engine and starts it.
- Waits for done, then writes the updated state back and emits the filtered sample tagged with its channel.

It sits between the sample sources (ADC framers) and a stateless SOS engine. This removes the need for one filter instance per channel.

Parameters:
NUM_CH, 4, number of channels (2..16)
DATA_SIZE, 24, sample width, two's complement
STATE_SIZE, 32, width of each SOS delay-state word (w1, w2)
TIMEOUT, 64, max cycles to wait for eng_done before abort

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  synchronous, active-low reset
flush  in  1  one-cycle pulse: zero all channel states
ch_valid  in  NUM_CH  per-channel sample strobe, one-cycle pulse
ch_data  in  NUM_CH*DATA_SIZE  packed samples, channel i at [i*DATA_SIZE +: DATA_SIZE]
eng_start  out  1  one-cycle start pulse to engine
eng_data_in  out  DATA_SIZE  sample to engine, held from start until done
eng_w1_in  out  STATE_SIZE  state w1 to engine
eng_w2_in  out  STATE_SIZE  state w2 to engine
eng_done  in  1  engine completion pulse
eng_data_out  in  DATA_SIZE  filtered sample, valid with eng_done
eng_w1_out  in  STATE_SIZE  updated w1, valid with eng_done
eng_w2_out  in  STATE_SIZE  updated w2, valid with eng_done
out_valid  out  1  one-cycle result strobe
out_data  out  DATA_SIZE  filtered sample
out_ch  out  clog2(NUM_CH)  channel index of out_data
overrun  out  NUM_CH  sticky: sample dropped on that channel
timeout_err  out  1  sticky: engine failed to finish within TIMEOUT

Behaviour:
- Reset (reset==0 at a clk edge) clears the following:
  - all outputs to 0;
  - all pending flags;
  - all state words;
  - the round-robin pointer, to 0;
  - the FSM, to IDLE.
  Reset takes effect in any state, mid-operation included. An in-flight engine result arriving afterwards is ignored.
- Capture: ch_valid[i] with pending[i]==0 loads sample_reg[i] and sets pending[i] at the next edge.
- Overrun: ch_valid[i] with pending[i]==1 drops the new sample and sets overrun[i] sticky. Only reset clears overrun.
- Same-cycle arrival and grant: ch_valid[i] on the cycle channel i is granted counts as a new capture. pending[i] stays 1 with the new data. The grant uses the old sample.
- FSM states IDLE -> ISSUE -> WAIT -> WBACK -> IDLE.
  - IDLE: if any pending, grant the first pending channel at or after rr_ptr, searching upward with wrap. At the same edge: latch sample and state into the engine operand registers, clear pending[g], set rr_ptr=(g+1) mod NUM_CH, go to ISSUE.
  - ISSUE: eng_start=1 for exactly this cycle; go to WAIT; clear the watchdog.
  - WAIT: the watchdog increments each cycle.
    - On eng_done: capture eng_*_out and go to WBACK.
    - If the watchdog reaches TIMEOUT first: set timeout_err, leave state unchanged, emit no output, go to IDLE.
  - WBACK: write w1/w2 for channel g; pulse out_valid for 1 cycle with out_data/out_ch; go to IDLE.
- Minimum latency from ch_valid to out_valid is 4 + engine latency cycles. An engine with done 1 cycle after start gives 5 cycles.
- eng_done outside WAIT is ignored.
- flush:
  - Zeros all state words at the next edge; pending samples are kept.
  - If asserted in WAIT or WBACK, the in-flight state writeback is suppressed (the state stays zero). out_valid is still emitted.
  - flush with a WBACK write in the same cycle: flush wins.
- eng_data_in, eng_w1_in and eng_w2_in hold stable from ISSUE through WAIT.
- No arithmetic is done here. Widths pass through unchanged.

Decomposition:
- Shared package sos_sched_pkg holds:
  - FSM state encoding (IDLE/ISSUE/WAIT/WBACK);
  - the CH_W = clog2(NUM_CH) helper;
  - the default TIMEOUT constant.
- One natural sub-module, rr_arbiter: pending vector plus rr_ptr in, one-hot grant and index out, combinational with no state.
- The state store is a register array inside the top. It is NUM_CH x 2 x STATE_SIZE.

Test Plan:
1. Single channel (NUM_CH=4), engine model with 1-cycle done: ch_valid[2] with 24'h000100, stub returning out = in+1 and w1 = w1+5 -> out_valid 5 cycles later, out_ch=2, out_data=24'h000101. A second sample on ch2 sees eng_w1_in=5.
2. Fairness: all four ch_valid in the same cycle -> out_ch order 0,1,2,3. Then with rr_ptr=1, samples on ch0 and ch3 -> order 3,0.
3. Overrun: ch_valid[1] twice while ch1 is pending (engine stalled with done held off 10 cycles) -> overrun=4'b0010. The first sample is processed and the second dropped.
4. Timeout: engine never asserts done, TIMEOUT=64 -> timeout_err=1 at 64 cycles after eng_start. No out_valid; channel state is unchanged; the next pending channel is served.
5. Flush during WAIT: flush while ch0 is in WAIT -> out_valid still fires, and the next ch0 start shows eng_w1_in=eng_w2_in=0.
6. Reset mid-WAIT: reset low for 1 cycle, then a stray eng_done -> no out_valid; all outputs, overrun and timeout_err read 0.
